// File: rtl/mem_ctrl.sv
// Byte-serial RAM port arbiter for instruction fetch (IF) and load/store (MEM) requesters.
// Optional: define MC_IO_STALL_EN to hold stores to the I/O window while the UART TX buffer is full.
module mem_ctrl #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [1:0]        if_status,
    output logic [DATA_W-1:0] if_data,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [1:0]        mem_len,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [1:0]        mem_status,
    output logic [DATA_W-1:0] mem_rdata,
    input  logic [7:0]        ram_din,
    output logic [7:0]        ram_dout,
    output logic [ADDR_W-1:0] ram_a,
    output logic              ram_wr,
    input  logic              io_buffer_full
);

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    localparam logic [1:0]        STAT_INIT = 2'b00;
    localparam logic [1:0]        STAT_BUSY = 2'b01;
    localparam logic [1:0]        STAT_DONE = 2'b10;
    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            state_r;
    logic              owner_mem_r;
    logic [2:0]        cnt_r;
    logic [2:0]        nbytes_r;
    logic [DATA_W-1:0] wdata_r;
    logic [DATA_W-1:0] rbuf_r;
    logic [ADDR_W-1:0] ram_a_r;
    logic [7:0]        ram_dout_r;
    logic              ram_wr_r;
    logic [1:0]        if_status_r;
    logic [1:0]        mem_status_r;
    logic [DATA_W-1:0] if_data_r;
    logic [DATA_W-1:0] mem_rdata_r;
    logic              stall_s;

    function automatic logic [2:0] len_to_bytes(input logic [1:0] len);
        case (len)
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] put_lane(input logic [DATA_W-1:0] word,
                                                   input logic [1:0] lane,
                                                   input logic [7:0] data);
        logic [DATA_W-1:0] res;
        res = word;
        res[{lane, 3'b000} +: 8] = data;
        return res;
    endfunction

    function automatic logic [7:0] get_lane(input logic [DATA_W-1:0] word,
                                            input logic [1:0] lane);
        return word[{lane, 3'b000} +: 8];
    endfunction

`ifdef MC_IO_STALL_EN
    // A store byte aimed at the UART window waits for TX buffer space.
    assign stall_s = (state_r == WR) && (ram_a_r[17:16] == 2'b11) && io_buffer_full;
`else
    logic unused_io_s;
    assign unused_io_s = io_buffer_full;
    assign stall_s     = 1'b0;
`endif

    assign ram_a      = ram_a_r;
    assign ram_dout   = ram_dout_r;
    assign ram_wr     = ram_wr_r & ~stall_s;
    assign if_status  = if_status_r;
    assign mem_status = mem_status_r;
    assign if_data    = if_data_r;
    assign mem_rdata  = mem_rdata_r;

    // Controller FSM; every output is registered so ram_a/ram_dout lead the cycle they apply to.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r      <= IDLE;
            owner_mem_r  <= 1'b0;
            cnt_r        <= 3'd0;
            nbytes_r     <= 3'd0;
            wdata_r      <= {DATA_W{1'b0}};
            rbuf_r       <= {DATA_W{1'b0}};
            ram_a_r      <= {ADDR_W{1'b0}};
            ram_dout_r   <= 8'h00;
            ram_wr_r     <= 1'b0;
            if_status_r  <= STAT_INIT;
            mem_status_r <= STAT_INIT;
            if_data_r    <= {DATA_W{1'b0}};
            mem_rdata_r  <= {DATA_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    cnt_r        <= 3'd0;
                    rbuf_r       <= {DATA_W{1'b0}};
                    if_status_r  <= STAT_INIT;
                    mem_status_r <= STAT_INIT;
                    if (mem_req) begin
                        owner_mem_r  <= 1'b1;
                        nbytes_r     <= len_to_bytes(mem_len);
                        wdata_r      <= mem_wdata;
                        ram_a_r      <= mem_addr;
                        mem_status_r <= STAT_BUSY;
                        if (mem_we) begin
                            state_r    <= WR;
                            ram_dout_r <= mem_wdata[7:0];
                            ram_wr_r   <= 1'b1;
                        end else begin
                            state_r  <= RD;
                            ram_wr_r <= 1'b0;
                        end
                    end else if (if_req) begin
                        owner_mem_r <= 1'b0;
                        nbytes_r    <= 3'd4;
                        ram_a_r     <= if_addr;
                        if_status_r <= STAT_BUSY;
                        state_r     <= RD;
                        ram_wr_r    <= 1'b0;
                    end else begin
                        ram_wr_r <= 1'b0;
                    end
                end
                RD: begin
                    // ram_din now holds the byte addressed one cycle earlier
                    if (cnt_r != 3'd0) begin
                        rbuf_r <= put_lane(rbuf_r, cnt_r[1:0] - 2'd1, ram_din);
                    end
                    if (cnt_r == nbytes_r) begin
                        state_r <= DONE;
                        if (owner_mem_r) begin
                            mem_status_r <= STAT_DONE;
                            mem_rdata_r  <= put_lane(rbuf_r, cnt_r[1:0] - 2'd1, ram_din);
                        end else begin
                            if_status_r <= STAT_DONE;
                            if_data_r   <= put_lane(rbuf_r, cnt_r[1:0] - 2'd1, ram_din);
                        end
                    end else begin
                        cnt_r   <= cnt_r + 3'd1;
                        ram_a_r <= ram_a_r + ADDR_ONE;
                    end
                end
                WR: begin
                    if (stall_s) begin
                        cnt_r <= cnt_r;
                    end else if (cnt_r == nbytes_r - 3'd1) begin
                        state_r  <= DONE;
                        ram_wr_r <= 1'b0;
                        if (owner_mem_r) begin
                            mem_status_r <= STAT_DONE;
                        end else begin
                            if_status_r <= STAT_DONE;
                        end
                    end else begin
                        cnt_r      <= cnt_r + 3'd1;
                        ram_a_r    <= ram_a_r + ADDR_ONE;
                        ram_dout_r <= get_lane(wdata_r, cnt_r[1:0] + 2'd1);
                    end
                end
                DONE: begin
                    state_r      <= IDLE;
                    ram_wr_r     <= 1'b0;
                    if_status_r  <= STAT_INIT;
                    mem_status_r <= STAT_INIT;
                end
                default: begin
                    state_r      <= IDLE;
                    ram_wr_r     <= 1'b0;
                    if_status_r  <= STAT_INIT;
                    mem_status_r <= STAT_INIT;
                end
            endcase
        end
    end

endmodule
